// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and sizing helpers for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Controller states; the encoding is fixed so that other blocks and
    // debug tooling can decode the state register directly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest operand the bit counter is sized for.
    localparam int MAX_WIDTH = 32;

    // Bit-counter width: clog2(WIDTH), never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder; combinational sum and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder. Latches operands on a start
//               handshake, then feeds one bit pair per clock (LSB first)
//               through a single full_adder, carrying between cycles.
//               Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that
//               turns the operation into a - b (cout=1 means no borrow).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done
);

    localparam int              CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    logic             w_fa_sum;
    logic             w_fa_cout;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_cnt == C_LAST);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so invert b and force the initial carry.
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    full_adder u_full_adder (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: IDLE -> RUN on accept, RUN -> DONE after the last bit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, then shift one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_in;
            r_carry <= w_c_in;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_fa_cout;
            end
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);
    assign sum   = r_sum;
    assign cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH=4) with a
//               result scoreboard checked on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt  = 0;
    int last_done = 0;
    int prev_done = 0;
    logic [WIDTH:0] exp_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .sum   (sum),
        .cout  (cout),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result {cout,sum}.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c, input logic s);
        logic [WIDTH-1:0] d;
        if (s) begin
            d = x - y;
            return {(x >= y), d};
        end
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [WIDTH:0] e;
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done got sum=%0d cout=%0d want no pulse", sum, cout);
            end else begin
                e = exp_q.pop_front();
                if ({cout, sum} !== e) begin
                    bad++;
                    $display("FAIL result got cout=%0d sum=%0d want cout=%0d sum=%0d",
                             cout, sum, e[WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    // Drives one operation from IDLE; returns cycles from accept to done.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic, input logic is, output int lat);
        a = ia; b = ib; cin = ic; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = is;
`endif
        exp_q.push_back(model(ia, ib, ic, is));
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", ready); end
        total++; if (busy  !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done  !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (sum   !== '0)   begin bad++; $display("FAIL reset_sum got=%0d want=0", sum); end
        total++; if (cout  !== 1'b0) begin bad++; $display("FAIL reset_cout got=%0b want=0", cout); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat;
        a = 4'd3; b = 4'd5; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        exp_q.push_back(model(4'd3, 4'd5, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy cycle=%0d got=%0b want=1", i, busy); end
            @(negedge clk);
        end
        lat = WIDTH;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done_cycle got=%0b want=1", done); end
        @(negedge clk);
        total++; if (ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL basic_ready_after got ready=%0b done=%0b want ready=1 done=0", ready, done);
        end
        total++; if ({cout, sum} !== 5'd8) begin bad++; $display("FAIL basic_hold got=%0d want=8", {cout, sum}); end
        if (lat != WIDTH) $display("latency note %0d", lat);
    endtask

    task automatic test_carry;
        int lat;
        run_op(4'd15, 4'd1, 1'b0, 1'b0, lat);
        total++; if (lat != WIDTH) begin bad++; $display("FAIL carry1_latency got=%0d want=%0d", lat, WIDTH); end
        run_op(4'd7, 4'd8, 1'b1, 1'b0, lat);
        total++; if (lat != WIDTH) begin bad++; $display("FAIL carry2_latency got=%0d want=%0d", lat, WIDTH); end
        repeat (3) @(negedge clk);
        total++; if ({cout, sum} !== 5'b10000) begin
            bad++; $display("FAIL carry_hold got cout=%0b sum=%0d want cout=1 sum=0", cout, sum);
        end
    endtask

    task automatic test_start_busy;
        int d0;
        int k;
        d0 = done_cnt;
        a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(4'd2, 4'd2, 1'b0, 1'b0));
        @(negedge clk);
        a = 4'd9; b = 4'd9;
        repeat (2) @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done_cnt < d0 + 1 && k < 30) begin @(negedge clk); k++; end
        repeat (8) @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL busy_start_pulses got=%0d want=1", done_cnt - d0); end
        total++; if ({cout, sum} !== 5'd4) begin bad++; $display("FAIL busy_start_hold got=%0d want=4", {cout, sum}); end
    endtask

    task automatic test_reset_mid;
        int d0;
        int lat;
        d0 = done_cnt;
        a = 4'd6; b = 4'd6; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(4'd6, 4'd6, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({ready, busy, done} !== 3'b100) begin
            bad++; $display("FAIL midreset_flags got ready=%0b busy=%0b done=%0b want 1 0 0", ready, busy, done);
        end
        total++; if ({cout, sum} !== '0) begin bad++; $display("FAIL midreset_result got=%0d want=0", {cout, sum}); end
        exp_q.delete();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (done_cnt != d0) begin bad++; $display("FAIL midreset_no_done got=%0d want=%0d", done_cnt - d0, 0); end
        run_op(4'd1, 4'd1, 1'b0, 1'b0, lat);
        total++; if (lat != WIDTH) begin bad++; $display("FAIL midreset_latency got=%0d want=%0d", lat, WIDTH); end
        total++; if ({cout, sum} !== 5'd2) begin bad++; $display("FAIL midreset_after got=%0d want=2", {cout, sum}); end
    endtask

    task automatic test_back_to_back;
        int d0;
        int k;
        d0 = done_cnt;
        a = 4'd1; b = 4'd2; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(4'd1, 4'd2, 1'b0, 1'b0));
        @(negedge clk);
        a = 4'd4; b = 4'd5; cin = 1'b1;
        exp_q.push_back(model(4'd4, 4'd5, 1'b1, 1'b0));
        k = 0;
        while (done_cnt < d0 + 1 && k < 30) begin @(negedge clk); k++; end
        k = 0;
        while (busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        start = 1'b0;
        k = 0;
        while (done_cnt < d0 + 2 && k < 30) begin @(negedge clk); k++; end
        total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", done_cnt - d0); end
        total++; if (last_done - prev_done != WIDTH + 2) begin
            bad++; $display("FAIL b2b_spacing got=%0d want=%0d", last_done - prev_done, WIDTH + 2);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat;
        run_op(4'd5, 4'd3, 1'b0, 1'b1, lat);
        total++; if ({cout, sum} !== 5'b10010) begin bad++; $display("FAIL sub1 got=%0d want=18", {cout, sum}); end
        run_op(4'd3, 4'd5, 1'b1, 1'b1, lat);
        total++; if ({cout, sum} !== 5'b01110) begin bad++; $display("FAIL sub2 got=%0d want=14", {cout, sum}); end
        sub = 1'b0;
    endtask
`endif

    task automatic test_sweep;
        int lat;
        for (int i = 0; i < (1 << WIDTH); i++) begin
            for (int j = 0; j < (1 << WIDTH); j++) begin
                for (int c = 0; c < 2; c++) begin
                    run_op(WIDTH'(i), WIDTH'(j), 1'(c), 1'b0, lat);
                    total++;
                    if (lat != WIDTH) begin
                        bad++; $display("FAIL sweep_latency a=%0d b=%0d c=%0d got=%0d want=%0d", i, j, c, lat, WIDTH);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_sweep();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
